dvs_polarity_filter_ctrl: RTL

- Sequences the DVS event stream through a runtime-configurable polarity filter and buffers accepted events in one output register for the RAVENS input stage.
- Sits between the DVS event decoder (upstream valid/ready) and the RAVENS spike injector (downstream valid/ready).
- Mode changes are applied only after the output register has drained, so no in-flight event is ever filtered under a mixed configuration.
- Counts passed and dropped events for host readout.

---
 rtl/dvs_polarity_filter_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dvs_polarity_filter_ctrl.sv
// Polarity filter between the DVS decoder and the RAVENS injector: one output register,
// 1-cycle accept-to-output latency; mode changes wait for the register to drain.
module dvs_polarity_filter_ctrl #(
  parameter int         X_WIDTH    = 8,
  parameter int         Y_WIDTH    = 8,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [1:0] RESET_MODE = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic [1:0]           cfg_mode,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_WIDTH-1:0]   in_x,
  input  logic [Y_WIDTH-1:0]   in_y,
  input  logic                 in_polarity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_WIDTH-1:0]   out_x,
  output logic [Y_WIDTH-1:0]   out_y,
  output logic                 out_polarity,
  output logic [1:0]           mode,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 busy
);

  typedef enum logic [1:0] {RUN, DRAIN, UPDATE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 out_valid_q, out_valid_d;
  logic [X_WIDTH-1:0]   out_x_q, out_x_d;
  logic [Y_WIDTH-1:0]   out_y_q, out_y_d;
  logic                 out_pol_q, out_pol_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic drop;
  logic accept;
  logic pass_load;

  assign drop = (mode_q == 2'b11) | ((mode_q == 2'b01) & ~in_polarity) |
                ((mode_q == 2'b10) & in_polarity);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_pol_d   = out_pol_q;
    pass_d      = pass_q;
    drop_d      = drop_q;

    in_ready  = (state_q == RUN) & ~cfg_valid & (~out_valid_q | out_ready);
    accept    = in_valid & in_ready;
    pass_load = accept & ~drop;

    case (state_q)
      RUN:     if (cfg_valid) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || out_ready) state_d = UPDATE;
      UPDATE:  state_d = RUN;
      default: state_d = RUN;
    endcase

    // A pop and a load in the same cycle keep the register full for full throughput.
    if (pass_load) begin
      out_valid_d = 1'b1;
      out_x_d     = in_x;
      out_y_d     = in_y;
      out_pol_d   = in_polarity;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == DRAIN && state_d == UPDATE) begin
      mode_d = cfg_mode;
      pass_d = '0;
      drop_d = '0;
    end else if (accept) begin
      if (!drop && pass_q != CNT_MAX) pass_d = pass_q + CNT_WIDTH'(1);
      if (drop && drop_q != CNT_MAX)  drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mode_q      <= RESET_MODE;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_pol_q   <= 1'b0;
      pass_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_pol_q   <= out_pol_d;
      pass_q      <= pass_d;
      drop_q      <= drop_d;
    end
  end

  assign cfg_ready    = (state_q == UPDATE);
  assign busy         = (state_q != RUN);
  assign out_valid    = out_valid_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_polarity = out_pol_q;
  assign mode         = mode_q;
  assign pass_count   = pass_q;
  assign drop_count   = drop_q;

endmodule
